// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants.
// Holds the default segment lengths, the derived totals and the first-active
// pixel/line positions that the framebuffer address generator also relies on,
// plus the raster state type used by the timing generator.
package vga_timing_pkg;

   // Horizontal segments, in pixels, in raster order from count 0.
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;

   // Vertical segments, in lines, in raster order from count 0.
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;

   localparam int unsigned H_TOTAL = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;  // 800
   localparam int unsigned V_TOTAL = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;  // 525

   // First active pixel / line; the address generator subtracts these.
   localparam int unsigned H_ACT_START = H_SYNC_DEF + H_BP_DEF;  // 144
   localparam int unsigned V_ACT_START = V_SYNC_DEF + V_BP_DEF;  // 35

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/vga_pixel_tick_gen.sv
// Pixel-rate prescaler.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - high for one clk every CLK_DIV clks (every clk when CLK_DIV = 1)
// The divider runs freely from reset regardless of whether the raster is running.
module vga_pixel_tick_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;

   always_comb begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign tick = (div_q == DIV_MAX);

endmodule

// File: rtl/vga_sync_timing_generator.sv
// VGA raster timing generator (640x480@60 by default).
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   en           - run request; low returns the raster to idle immediately
//   hcnt_addr    - horizontal position, 0..H_TOTAL-1
//   vcnt_addr    - vertical position, 0..V_TOTAL-1
//   dena         - display enable, high inside the active window
//   hsync_n      - horizontal sync, active low
//   vsync_n      - vertical sync, active low
//   pix_stb      - one-clk pulse whenever the position outputs advance
//   line_start   - one-clk pulse when hcnt_addr becomes 0
//   frame_start  - one-clk pulse when the position becomes (0,0)
// All outputs are registered and decoded from the next position, so the syncs
// and dena always describe the position currently presented.
module vga_sync_timing_generator
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [9:0] hcnt_addr,
   output logic [9:0] vcnt_addr,
   output logic       dena,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       pix_stb,
   output logic       line_start,
   output logic       frame_start
);

   localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

   generate
      if (H_TOT > 1024 || V_TOT > 1024 || CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_cfg
         $error("vga_sync_timing_generator: illegal timing configuration");
      end
   endgenerate

   // 11-bit bounds so H_TOT-1 / active end cannot wrap at 10 bits.
   localparam logic [10:0] H_LAST     = 11'(H_TOT - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOT - 1);
   localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
   localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
   localparam logic [10:0] H_ACT_LO   = 11'(H_SYNC + H_BP);
   localparam logic [10:0] H_ACT_HI   = 11'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [10:0] V_ACT_LO   = 11'(V_SYNC + V_BP);
   localparam logic [10:0] V_ACT_HI   = 11'(V_SYNC + V_BP + V_ACTIVE);

   logic        tick;
   state_e      state_q, state_d;
   logic [9:0]  h_d, v_d;
   logic [10:0] h_ext, v_ext;
   logic        adv;
   logic        run_d;
   logic        dena_d, hsync_n_d, vsync_n_d, line_start_d, frame_start_d;

   vga_pixel_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; dropping en abandons the frame without waiting for a tick.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tick && en) state_d = RUN;
         RUN:     if (!en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next position and decoded outputs
   always_comb begin
      h_d = hcnt_addr;
      v_d = vcnt_addr;
      adv = 1'b0;
      case (state_q)
         IDLE: begin
            h_d = '0;
            v_d = '0;
            adv = tick && en;
         end
         RUN: begin
            if (!en) begin
               h_d = '0;
               v_d = '0;
            end else if (tick) begin
               adv = 1'b1;
               if ({1'b0, hcnt_addr} == H_LAST) begin
                  h_d = '0;
                  v_d = ({1'b0, vcnt_addr} == V_LAST) ? '0 : vcnt_addr + 10'd1;
               end else begin
                  h_d = hcnt_addr + 10'd1;
               end
            end
         end
         default: begin
            h_d = '0;
            v_d = '0;
         end
      endcase

      h_ext         = {1'b0, h_d};
      v_ext         = {1'b0, v_d};
      run_d         = (state_d == RUN);
      dena_d        = run_d && (h_ext >= H_ACT_LO) && (h_ext < H_ACT_HI)
                            && (v_ext >= V_ACT_LO) && (v_ext < V_ACT_HI);
      hsync_n_d     = !(run_d && (h_ext < H_SYNC_END));
      vsync_n_d     = !(run_d && (v_ext < V_SYNC_END));
      line_start_d  = adv && (h_d == 10'd0);
      frame_start_d = adv && (h_d == 10'd0) && (v_d == 10'd0);
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_addr   <= '0;
         vcnt_addr   <= '0;
         dena        <= 1'b0;
         hsync_n     <= 1'b1;
         vsync_n     <= 1'b1;
         pix_stb     <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hcnt_addr   <= h_d;
         vcnt_addr   <= v_d;
         dena        <= dena_d;
         hsync_n     <= hsync_n_d;
         vsync_n     <= vsync_n_d;
         pix_stb     <= adv;
         line_start  <= line_start_d;
         frame_start <= frame_start_d;
      end
   end

endmodule

// File: tb/tb_vga_sync_timing_generator.sv
// Bench for vga_sync_timing_generator. Two instances with a reduced raster
// (17x10) so whole frames fit in a short run: one with CLK_DIV=2, one with
// CLK_DIV=1. A position-index reference model predicts every output each clk.
module tb_vga_sync_timing_generator;

   localparam int unsigned HS = 4, HB = 3, HA = 8, HF = 2;
   localparam int unsigned VS = 2, VB = 2, VA = 5, VF = 1;
   localparam int unsigned HT = HS + HB + HA + HF;  // 17
   localparam int unsigned VT = VS + VB + VA + VF;  // 10
   localparam int unsigned FRAME_PIX = HT * VT;

   logic clk = 1'b0;
   logic rst_n;
   logic en;

   logic [9:0] hc[2];
   logic [9:0] vc[2];
   logic de[2], hsn[2], vsn[2], ps[2], ls[2], fs[2];

   always #5 clk = ~clk;

   vga_sync_timing_generator #(
      .CLK_DIV (2), .H_SYNC (HS), .H_BP (HB), .H_ACTIVE (HA), .H_FP (HF),
      .V_SYNC (VS), .V_BP (VB), .V_ACTIVE (VA), .V_FP (VF)
   ) u_dut0 (
      .clk (clk), .rst_n (rst_n), .en (en),
      .hcnt_addr (hc[0]), .vcnt_addr (vc[0]), .dena (de[0]),
      .hsync_n (hsn[0]), .vsync_n (vsn[0]), .pix_stb (ps[0]),
      .line_start (ls[0]), .frame_start (fs[0])
   );

   vga_sync_timing_generator #(
      .CLK_DIV (1), .H_SYNC (HS), .H_BP (HB), .H_ACTIVE (HA), .H_FP (HF),
      .V_SYNC (VS), .V_BP (VB), .V_ACTIVE (VA), .V_FP (VF)
   ) u_dut1 (
      .clk (clk), .rst_n (rst_n), .en (en),
      .hcnt_addr (hc[1]), .vcnt_addr (vc[1]), .dena (de[1]),
      .hsync_n (hsn[1]), .vsync_n (vsn[1]), .pix_stb (ps[1]),
      .line_start (ls[1]), .frame_start (fs[1])
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: clks since reset release, running flag, linear pixel index.
   int unsigned kcnt[2];
   int unsigned idx[2];
   bit          run[2];
   bit          pst[2];

   // Frame statistics
   bit          started[2];
   int unsigned since[2], cnt_de[2], cnt_hs[2], cnt_vs[2];

   function automatic int unsigned dv(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         kcnt[i] = 0;
         idx[i]  = 0;
         run[i]  = 1'b0;
         pst[i]  = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         bit tk;
         tk = (kcnt[i] % dv(i)) == dv(i) - 1;
         kcnt[i]++;
         if (!run[i]) begin
            if (tk && en) begin
               run[i] = 1'b1;
               idx[i] = 0;
               pst[i] = 1'b1;
            end else begin
               pst[i] = 1'b0;
            end
         end else if (!en) begin
            run[i] = 1'b0;
            pst[i] = 1'b0;
         end else if (tk) begin
            idx[i] = (idx[i] + 1) % FRAME_PIX;
            pst[i] = 1'b1;
         end else begin
            pst[i] = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         int unsigned h, v;
         bit e_de, e_hs, e_vs, e_ps, e_ls, e_fs;
         if (!run[i]) begin
            h = 0; v = 0; e_de = 0; e_hs = 1; e_vs = 1; e_ps = 0; e_ls = 0; e_fs = 0;
         end else begin
            h    = idx[i] % HT;
            v    = idx[i] / HT;
            e_de = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
            e_hs = (h >= HS);
            e_vs = (v >= VS);
            e_ps = pst[i];
            e_ls = pst[i] && (h == 0);
            e_fs = pst[i] && (idx[i] == 0);
         end
         chk($sformatf("dut%0d_hcnt", i), 32'(hc[i]), 32'(h));
         chk($sformatf("dut%0d_vcnt", i), 32'(vc[i]), 32'(v));
         chk($sformatf("dut%0d_dena", i), 32'(de[i]), 32'(e_de));
         chk($sformatf("dut%0d_hsync_n", i), 32'(hsn[i]), 32'(e_hs));
         chk($sformatf("dut%0d_vsync_n", i), 32'(vsn[i]), 32'(e_vs));
         chk($sformatf("dut%0d_pix_stb", i), 32'(ps[i]), 32'(e_ps));
         chk($sformatf("dut%0d_line_start", i), 32'(ls[i]), 32'(e_ls));
         chk($sformatf("dut%0d_frame_start", i), 32'(fs[i]), 32'(e_fs));
      end
   endtask

   // One clk: model follows the edge, outputs checked on the falling edge.
   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      check_all();
   endtask

   // Asynchronous reset asserted just after an active edge, released next negedge.
   task automatic mid_reset();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
   endtask

   // Steps after a release until each instance shows frame_start.
   task automatic check_start_latency(input string tag);
      int unsigned lat[2];
      lat[0] = 0;
      lat[1] = 0;
      for (int s = 1; s <= 4; s++) begin
         step();
         for (int i = 0; i < 2; i++) if (lat[i] == 0 && fs[i] === 1'b1) lat[i] = s;
      end
      chk({tag, "_dut0_first_fs"}, lat[0], 2);
      chk({tag, "_dut1_first_fs"}, lat[1], 1);
   endtask

   task automatic stats_update();
      for (int i = 0; i < 2; i++) begin
         since[i]++;
         if (fs[i] === 1'b1) begin
            if (started[i]) begin
               chk($sformatf("dut%0d_frame_period", i), since[i], FRAME_PIX * dv(i));
               chk($sformatf("dut%0d_dena_pixels", i), cnt_de[i], HA * VA);
               chk($sformatf("dut%0d_hsync_low_pixels", i), cnt_hs[i], HS * VT);
               chk($sformatf("dut%0d_vsync_low_pixels", i), cnt_vs[i], VS * HT);
            end
            started[i] = 1'b1;
            since[i]   = 0;
            cnt_de[i]  = 0;
            cnt_hs[i]  = 0;
            cnt_vs[i]  = 0;
         end
         if (ps[i] === 1'b1) begin
            if (de[i] === 1'b1) cnt_de[i]++;
            if (hsn[i] === 1'b0) cnt_hs[i]++;
            if (vsn[i] === 1'b0) cnt_vs[i]++;
         end
      end
   endtask

   initial begin
      int unsigned pulses;
      bit found;

      // Reset held, en low
      rst_n = 1'b0;
      en    = 1'b0;
      model_reset();
      repeat (3) step();
      @(negedge clk);
      rst_n = 1'b1;

      // Idle for 100 clks with en low: no pulses at all
      pulses = 0;
      for (int s = 0; s < 100; s++) begin
         step();
         for (int i = 0; i < 2; i++) pulses += ps[i] + ls[i] + fs[i];
      end
      chk("idle_pulse_count", pulses, 0);

      // Release with en already high
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      en    = 1'b1;
      rst_n = 1'b1;
      check_start_latency("release");

      // Several whole frames with statistics
      for (int i = 0; i < 2; i++) started[i] = 1'b0;
      for (int s = 0; s < 3 * FRAME_PIX * 2 + 10; s++) begin
         step();
         stats_update();
      end
      chk("dut0_frames_seen", 32'(started[0]), 1);

      // Drop en at (8,4) on the CLK_DIV=2 instance
      found = 1'b0;
      for (int s = 0; s < 2000 && !found; s++) begin
         step();
         if (hc[0] == 10'd8 && vc[0] == 10'd4) found = 1'b1;
      end
      chk("reach_8_4", 32'(found), 1);
      en = 1'b0;
      step();
      chk("drop_hsync_n", 32'(hsn[0]), 1);
      chk("drop_dena", 32'(de[0]), 0);
      repeat (5) step();
      en = 1'b1;
      found = 1'b0;
      for (int s = 0; s < 6 && !found; s++) begin
         step();
         if (fs[0] === 1'b1) found = 1'b1;
      end
      chk("restart_frame_start", 32'(found), 1);
      chk("restart_hcnt", 32'(hc[0]), 0);

      // Asynchronous reset at (10,6) right after an edge, then release timing
      found = 1'b0;
      for (int s = 0; s < 2000 && !found; s++) begin
         if (hc[0] == 10'd10 && vc[0] == 10'd6) found = 1'b1;
         else step();
      end
      chk("reach_10_6", 32'(found), 1);
      mid_reset();
      check_start_latency("midreset");

      // Randomized en activity with occasional asynchronous resets
      for (int s = 0; s < 3000; s++) begin
         if (en) en = ($urandom_range(0, 79) != 0);
         else    en = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 499) == 0) mid_reset();
         else step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
